// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman game blocks.
//   - Game state codes driven by the level selector.
//   - Word geometry: letter code width, positions per word, alphabet size.
//   - Empty-position threshold: letter codes at or above it mark a blank slot.
package hangman_pkg;

    typedef enum logic [3:0] {
        GS_START    = 4'd0,
        GS_INGAME   = 4'd1,
        GS_WINGAME  = 4'd2,
        GS_LOSTGAME = 4'd3
    } game_state_t;

    localparam int LETTER_W = 5;
    localparam int WORD_LEN = 6;
    localparam int ALPHA    = 26;

    localparam logic [LETTER_W-1:0] EMPTY_CODE = 5'd26;

    // True when a letter code denotes an unused word position.
    function automatic logic is_empty_code(input logic [LETTER_W-1:0] code);
        return code >= EMPTY_CODE;
    endfunction

endpackage

// File: rtl/guess_checker.sv
// guess_checker: per-guess scoring engine for the hangman game.
// Latches the selected word/mask when the game enters INGAME, accepts one
// letter per valid/ready handshake, scans the six positions serially and
// reports hit/miss, win and loss back to the level selector.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   current_state   - game state from the level selector (START/INGAME/...)
//   word            - six 5-bit letter codes, position 0 in the top bits
//   mask            - bit i set when letter i occurs in word
//   guess_valid     - a guess is offered
//   guess_letter    - offered letter code
//   guess_ready     - a guess can be accepted this cycle
//   revealed        - bit p set when position p is shown
//   used            - bit i set when letter i has been guessed
//   wrong_count     - misses so far (saturating at MAX_WRONG)
//   repeat_guess    - one-cycle pulse after an ignored guess
//   win_game        - every position revealed
//   lost_game       - wrong_count reached MAX_WRONG
module guess_checker
    import hangman_pkg::*;
#(
    parameter int MAX_WRONG = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   current_state,
    input  logic [LETTER_W*WORD_LEN-1:0] word,
    input  logic [ALPHA-1:0]             mask,
    input  logic                         guess_valid,
    input  logic [LETTER_W-1:0]          guess_letter,
    output logic                         guess_ready,
    output logic [WORD_LEN-1:0]          revealed,
    output logic [ALPHA-1:0]             used,
    output logic [2:0]                   wrong_count,
    output logic                         repeat_guess,
    output logic                         win_game,
    output logic                         lost_game
);

    localparam logic [2:0] WRONG_LIMIT = 3'(MAX_WRONG);
    localparam logic [2:0] LAST_POS    = 3'(WORD_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SCAN,
        S_RESOLVE,
        S_END
    } chk_state_t;

    chk_state_t state, state_next;

    logic [LETTER_W*WORD_LEN-1:0] word_q;
    logic [ALPHA-1:0]             mask_q;
    logic [LETTER_W-1:0]          letter_q;
    logic [2:0]                   scan_cnt;

    logic                         in_game;
    logic                         accept;
    logic                         guess_ok;
    logic                         hit_pos;
    logic                         miss;
    logic [2:0]                   wrong_next;
    logic                         win_now;
    logic                         lost_now;

    // Letter code at position p; position 0 sits in the most significant bits.
    function automatic logic [LETTER_W-1:0] pos_code(
        input logic [LETTER_W*WORD_LEN-1:0] w,
        input int                           p
    );
        return w[LETTER_W*(WORD_LEN-1-p) +: LETTER_W];
    endfunction

    // Positions holding an empty code start out revealed.
    function automatic logic [WORD_LEN-1:0] empty_map(
        input logic [LETTER_W*WORD_LEN-1:0] w
    );
        logic [WORD_LEN-1:0] m;
        m = '0;
        for (int p = 0; p < WORD_LEN; p++) begin
            m[p] = is_empty_code(pos_code(w, p));
        end
        return m;
    endfunction

    // One-hot letter vector; codes beyond the alphabet shift out to zero,
    // which keeps the used/mask lookups safe for out-of-range codes.
    function automatic logic [ALPHA-1:0] letter_bit(input logic [LETTER_W-1:0] l);
        return ALPHA'(1) << l;
    endfunction

    always_comb begin
        in_game     = (current_state == GS_INGAME);
        guess_ready = (state == S_WAIT);
        accept      = guess_valid && guess_ready;
        guess_ok    = (guess_letter < EMPTY_CODE) &&
                      ((used & letter_bit(guess_letter)) == '0);

        // Single 5-bit compare against the position picked by the scan counter.
        hit_pos     = (pos_code(word_q, int'(scan_cnt)) == letter_q);

        // The mask, not the scan, decides hit versus miss.
        miss        = ((mask_q & letter_bit(letter_q)) == '0);
        if (miss && (wrong_count < WRONG_LIMIT)) begin
            wrong_next = wrong_count + 3'd1;
        end else begin
            wrong_next = wrong_count;
        end
        win_now     = &revealed;
        lost_now    = !win_now && (wrong_next == WRONG_LIMIT);
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_game) state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = in_game ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!in_game)                 state_next = S_IDLE;
                else if (accept && guess_ok)  state_next = S_SCAN;
            end
            S_SCAN: begin
                if (!in_game)                 state_next = S_IDLE;
                else if (scan_cnt == LAST_POS) state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                if (!in_game)                 state_next = S_IDLE;
                else if (win_now || lost_now) state_next = S_END;
                else                          state_next = S_WAIT;
            end
            S_END: begin
                if (!in_game) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q       <= '0;
            mask_q       <= '0;
            letter_q     <= '0;
            scan_cnt     <= '0;
            revealed     <= '0;
            used         <= '0;
            wrong_count  <= '0;
            repeat_guess <= 1'b0;
            win_game     <= 1'b0;
            lost_game    <= 1'b0;
        end else begin
            repeat_guess <= accept && in_game && !guess_ok;

            case (state)
                S_LOAD: begin
                    word_q      <= word;
                    mask_q      <= mask;
                    revealed    <= empty_map(word);
                    used        <= '0;
                    wrong_count <= '0;
                    win_game    <= 1'b0;
                    lost_game   <= 1'b0;
                end
                S_WAIT: begin
                    if (in_game && accept && guess_ok) begin
                        letter_q <= guess_letter;
                        used     <= used | letter_bit(guess_letter);
                        scan_cnt <= '0;
                    end
                end
                S_SCAN: begin
                    if (in_game) begin
                        if (hit_pos) revealed[scan_cnt] <= 1'b1;
                        scan_cnt <= scan_cnt + 3'd1;
                    end
                end
                S_RESOLVE: begin
                    if (in_game) begin
                        wrong_count <= wrong_next;
                        win_game    <= win_now;
                        lost_game   <= lost_now;
                    end
                end
                default: begin
                end
            endcase

            // Result flags drop on the way back to IDLE; revealed and
            // wrong_count stay for display until the next LOAD.
            if (state != S_IDLE && state_next == S_IDLE) begin
                win_game  <= 1'b0;
                lost_game <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_guess_checker.sv
module tb_guess_checker;
    import hangman_pkg::*;

    localparam int MAX_WRONG = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  current_state;
    logic [29:0] word;
    logic [25:0] mask;
    logic        guess_valid;
    logic [4:0]  guess_letter;
    logic        guess_ready;
    logic [5:0]  revealed;
    logic [25:0] used;
    logic [2:0]  wrong_count;
    logic        repeat_guess;
    logic        win_game;
    logic        lost_game;

    guess_checker #(.MAX_WRONG(MAX_WRONG)) dut (
        .clk          (clk),
        .reset        (reset),
        .current_state(current_state),
        .word         (word),
        .mask         (mask),
        .guess_valid  (guess_valid),
        .guess_letter (guess_letter),
        .guess_ready  (guess_ready),
        .revealed     (revealed),
        .used         (used),
        .wrong_count  (wrong_count),
        .repeat_guess (repeat_guess),
        .win_game     (win_game),
        .lost_game    (lost_game)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the game as a set of guessed letters.
    logic [4:0]  m_word [6];
    logic [25:0] m_mask;
    logic [25:0] m_used;
    logic        m_win;
    logic        m_lost;

    typedef struct {
        logic       start;
        logic [4:0] letter;
        logic       rep;
        logic [5:0] rev;
        logic [2:0] wrong;
        logic       win;
        logic       lost;
        logic       ready;
    } vec_t;

    vec_t vtab [14];

    localparam logic [29:0] HANGED = {5'd7, 5'd0, 5'd13, 5'd6, 5'd4, 5'd3};
    localparam logic [29:0] BODY   = {5'd1, 5'd14, 5'd3, 5'd24, 5'd31, 5'd31};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [4:0] l, input logic r,
                                input logic [5:0] rv, input logic [2:0] w,
                                input logic wn, input logic ls, input logic rd);
        vec_t v;
        v.start = s; v.letter = l; v.rep = r; v.rev = rv;
        v.wrong = w; v.win = wn; v.lost = ls; v.ready = rd;
        return v;
    endfunction

    function automatic logic model_used(input logic [4:0] l);
        if (l >= 5'd26) return 1'b1;
        return m_used[l];
    endfunction

    // A position is shown if it is blank or its letter has been guessed.
    function automatic logic [5:0] model_revealed();
        logic [5:0] r;
        for (int p = 0; p < 6; p++) begin
            if (m_word[p] >= 5'd26) r[p] = 1'b1;
            else                    r[p] = m_used[m_word[p]];
        end
        return r;
    endfunction

    // Misses are guessed letters absent from the mask, capped at MAX_WRONG.
    function automatic logic [2:0] model_wrong();
        int c = 0;
        for (int i = 0; i < 26; i++) if (m_used[i] && !m_mask[i]) c++;
        if (c > MAX_WRONG) c = MAX_WRONG;
        return 3'(c);
    endfunction

    task automatic start_game(input logic [29:0] w);
        m_mask = '0;
        for (int p = 0; p < 6; p++) begin
            m_word[p] = w[29-5*p -: 5];
            if (m_word[p] < 5'd26) m_mask[m_word[p]] = 1'b1;
        end
        m_used = '0;
        m_win  = 1'b0;
        m_lost = 1'b0;
        word   = w;
        mask   = m_mask;
        current_state = 4'(GS_START);
        tick;
        tick;
        current_state = 4'(GS_INGAME);
        tick;
        tick;
        chk("load_revealed", 32'(revealed), 32'(model_revealed()));
        chk("load_ready", 32'(guess_ready), 32'd1);
        chk("load_wrong", 32'(wrong_count), 32'd0);
        chk("load_used", 32'(used), 32'd0);
    endtask

    task automatic do_guess(input logic [4:0] l, input logic from_tab, input vec_t tv);
        vec_t e;
        logic rep_m;
        int   n;
        rep_m = model_used(l);
        if (!rep_m) begin
            m_used[l] = 1'b1;
            m_win  = &model_revealed();
            m_lost = !m_win && (model_wrong() == 3'(MAX_WRONG));
        end
        if (from_tab) begin
            e = tv;
        end else begin
            e = mk(1'b0, l, rep_m, model_revealed(), model_wrong(), m_win, m_lost,
                   !(m_win || m_lost));
        end

        n = 0;
        while (!guess_ready && n < 20) begin
            tick;
            n++;
        end
        if (!guess_ready) begin
            chk("ready_timeout", 32'(guess_ready), 32'd1);
            return;
        end

        guess_valid  = 1'b1;
        guess_letter = l;
        tick;
        guess_valid  = 1'b0;

        if (e.rep) begin
            chk($sformatf("rep_pulse[%0d]", l), 32'(repeat_guess), 32'd1);
            chk($sformatf("rep_revealed[%0d]", l), 32'(revealed), 32'(e.rev));
            chk($sformatf("rep_wrong[%0d]", l), 32'(wrong_count), 32'(e.wrong));
            chk($sformatf("rep_ready[%0d]", l), 32'(guess_ready), 32'd1);
            tick;
            chk($sformatf("rep_pulse_end[%0d]", l), 32'(repeat_guess), 32'd0);
        end else begin
            chk($sformatf("no_rep[%0d]", l), 32'(repeat_guess), 32'd0);
            repeat (6) tick;
            chk($sformatf("busy_ready[%0d]", l), 32'(guess_ready), 32'd0);
            tick;
            chk($sformatf("revealed[%0d]", l), 32'(revealed), 32'(e.rev));
            chk($sformatf("wrong[%0d]", l), 32'(wrong_count), 32'(e.wrong));
            chk($sformatf("win[%0d]", l), 32'(win_game), 32'(e.win));
            chk($sformatf("lost[%0d]", l), 32'(lost_game), 32'(e.lost));
            chk($sformatf("ready[%0d]", l), 32'(guess_ready), 32'(e.ready));
            chk($sformatf("used[%0d]", l), 32'(used), 32'(m_used));
        end
    endtask

    initial begin
        vec_t       dummy;
        logic [29:0] w;
        logic [4:0]  code;
        int          g;

        vtab[0]  = mk(1'b1, 5'd0,  1'b0, 6'b000010, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[1]  = mk(1'b0, 5'd0,  1'b1, 6'b000010, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[2]  = mk(1'b0, 5'd28, 1'b1, 6'b000010, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[3]  = mk(1'b0, 5'd7,  1'b0, 6'b000011, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[4]  = mk(1'b0, 5'd13, 1'b0, 6'b000111, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[5]  = mk(1'b0, 5'd6,  1'b0, 6'b001111, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[6]  = mk(1'b0, 5'd4,  1'b0, 6'b011111, 3'd0, 1'b0, 1'b0, 1'b1);
        vtab[7]  = mk(1'b0, 5'd3,  1'b0, 6'b111111, 3'd0, 1'b1, 1'b0, 1'b0);
        vtab[8]  = mk(1'b1, 5'd1,  1'b0, 6'b000000, 3'd1, 1'b0, 1'b0, 1'b1);
        vtab[9]  = mk(1'b0, 5'd2,  1'b0, 6'b000000, 3'd2, 1'b0, 1'b0, 1'b1);
        vtab[10] = mk(1'b0, 5'd5,  1'b0, 6'b000000, 3'd3, 1'b0, 1'b0, 1'b1);
        vtab[11] = mk(1'b0, 5'd8,  1'b0, 6'b000000, 3'd4, 1'b0, 1'b0, 1'b1);
        vtab[12] = mk(1'b0, 5'd25, 1'b0, 6'b000000, 3'd5, 1'b0, 1'b0, 1'b1);
        vtab[13] = mk(1'b0, 5'd9,  1'b0, 6'b000000, 3'd6, 1'b0, 1'b1, 1'b0);
        dummy = vtab[0];

        reset         = 1'b1;
        current_state = 4'(GS_START);
        word          = '0;
        mask          = '0;
        guess_valid   = 1'b0;
        guess_letter  = '0;
        tick;
        tick;
        chk("rst_revealed", 32'(revealed), 32'd0);
        chk("rst_used", 32'(used), 32'd0);
        chk("rst_wrong", 32'(wrong_count), 32'd0);
        chk("rst_flags", 32'({repeat_guess, win_game, lost_game}), 32'd0);
        chk("rst_ready", 32'(guess_ready), 32'd0);
        reset = 1'b0;
        tick;
        chk("idle_ready", 32'(guess_ready), 32'd0);

        // Table-driven games on HANGED: a win with repeats, then six misses.
        for (int i = 0; i < 14; i++) begin
            if (vtab[i].start) start_game(HANGED);
            do_guess(vtab[i].letter, 1'b1, vtab[i]);
        end

        // END holds the loss until the game leaves INGAME, then drops the flag.
        tick;
        tick;
        chk("end_lost_held", 32'(lost_game), 32'd1);
        chk("end_ready", 32'(guess_ready), 32'd0);
        current_state = 4'(GS_LOSTGAME);
        tick;
        chk("end_lost_clear", 32'(lost_game), 32'd0);
        chk("end_wrong_held", 32'(wrong_count), 32'd6);
        tick;
        chk("end_idle_ready", 32'(guess_ready), 32'd0);

        // Four-letter word with blank trailing positions.
        start_game(BODY);
        chk("body_load_rev", 32'(revealed), 32'b110000);
        do_guess(5'd1,  1'b0, dummy);
        do_guess(5'd14, 1'b0, dummy);
        do_guess(5'd3,  1'b0, dummy);
        do_guess(5'd24, 1'b0, dummy);
        chk("body_win", 32'(win_game), 32'd1);

        // Reset in the middle of a scan.
        start_game(HANGED);
        guess_valid  = 1'b1;
        guess_letter = 5'd7;
        tick;
        guess_valid  = 1'b0;
        tick;
        tick;
        reset = 1'b1;
        tick;
        chk("mid_rst_revealed", 32'(revealed), 32'd0);
        chk("mid_rst_used", 32'(used), 32'd0);
        chk("mid_rst_wrong", 32'(wrong_count), 32'd0);
        chk("mid_rst_flags", 32'({repeat_guess, win_game, lost_game}), 32'd0);
        chk("mid_rst_ready", 32'(guess_ready), 32'd0);
        reset = 1'b0;
        tick;
        chk("post_rst_load_ready", 32'(guess_ready), 32'd0);
        tick;
        chk("post_rst_wait_ready", 32'(guess_ready), 32'd1);

        // Game leaves INGAME in the middle of a scan.
        start_game(HANGED);
        do_guess(5'd1, 1'b0, dummy);
        guess_valid  = 1'b1;
        guess_letter = 5'd13;
        tick;
        guess_valid  = 1'b0;
        tick;
        tick;
        current_state = 4'(GS_START);
        tick;
        chk("abort_ready", 32'(guess_ready), 32'd0);
        chk("abort_wrong_held", 32'(wrong_count), 32'd1);
        chk("abort_flags", 32'({win_game, lost_game}), 32'd0);
        tick;
        tick;
        chk("abort_idle_ready", 32'(guess_ready), 32'd0);
        chk("abort_wrong_after", 32'(wrong_count), 32'd1);

        // Randomized games against the reference model.
        for (int gm = 0; gm < 8; gm++) begin
            w = '0;
            for (int p = 0; p < 6; p++) begin
                if ($urandom_range(0, 4) == 0) code = 5'(26 + $urandom_range(0, 5));
                else                           code = 5'($urandom_range(0, 25));
                w[29-5*p -: 5] = code;
            end
            start_game(w);
            g = 0;
            while (!(m_win || m_lost) && g < 60) begin
                if ($urandom_range(0, 1) == 1) code = m_word[$urandom_range(0, 5)];
                else                           code = 5'($urandom_range(0, 31));
                do_guess(code, 1'b0, dummy);
                g++;
            end
        end

        current_state = 4'(GS_START);
        tick;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
